// File: rtl/maze_pkg.sv
// Shared maze-bot definitions: direction/speed/colour codes, reset position, and the toad sprite image.
// Used by the maze bot and by toad_icon_render.
package maze_pkg;

  typedef enum logic [2:0] {
    NORTH, NORTHEAST, EAST, SOUTHEAST, SOUTH, SOUTHWEST, WEST, NORTHWEST
  } dir_e;

  typedef enum logic [1:0] {IDLE, SLOWEST, SLOW, FAST} speed_e;

  typedef enum logic [1:0] {WHITE, BLACK, RED} map_colour_e;

  localparam logic [7:0] START_X = 8'd68;
  localparam logic [7:0] START_Y = 8'd60;

  // 16x16 sprite, 2 bits per pixel; row dy occupies bits [32*dy +: 32], pixel dx within a row at [2*dx +: 2].
  localparam logic [511:0] TOAD_IMAGE = {
    32'hC000_0003, 32'h5000_0005, 32'h1400_0014, 32'h0510_0450,
    32'h0155_5540, 32'h0555_5550, 32'h1555_5554, 32'h5555_5555,
    32'h5A55_55A5, 32'h5555_5555, 32'h56AA_AA95, 32'h15FF_FF54,
    32'h05AA_5A53, 32'h0155_5540, 32'h0015_5400, 32'h0000_0001
  };

  function automatic logic faces_west(input dir_e d);
    return (d == SOUTHWEST) || (d == WEST) || (d == NORTHWEST);
  endfunction

endpackage

// File: rtl/toad_icon_rom.sv
// 256x2 synchronous-read sprite ROM, one cycle read latency.
// Contents match toad_icon.mem and are held as a package constant so no file read is needed.
module toad_icon_rom
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] i_addr,
  output logic [1:0] o_data
);

  // NOTE: ROM read register carries no reset; downstream hit_q gates it, so its power-up value never shows.
  always_ff @(posedge clk) begin
    o_data <= TOAD_IMAGE[{i_addr, 1'b0} +: 2];
  end

endmodule

// File: rtl/toad_icon_render.sv
// Draws the maze bot as a 16x16 toad sprite over the VGA raster, two-clock pixel latency.
// Optional feature macro: BLINK_ON_DEADLOCK_EN (deadlocked sprite blinks instead of hiding).
module toad_icon_render
  import maze_pkg::*;
#(
  parameter int SCALE_SHIFT  = 2,
  parameter int X_OFFSET     = 256,
  parameter int Y_OFFSET     = 128,
  parameter int ICON_W       = 16,
  parameter int BLINK_FRAMES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        video_on,
  input  logic [11:0] pixel_row,
  input  logic [11:0] pixel_column,
  input  logic [7:0]  loc_x,
  input  logic [7:0]  loc_y,
  input  logic [2:0]  direction,
  input  logic        deadlock,
  output logic [1:0]  icon,
  output logic        frame_tick
);

  localparam int IW = $clog2(ICON_W);

  logic        r_vsync_q, r_frame_tick, r_dead;
  logic [7:0]  r_loc_x, r_loc_y;
  dir_e        r_dir;
  logic        w_vsync_rise, w_pos_en, w_show, w_hit;
  logic [11:0] w_left, w_top;
  logic [IW-1:0] w_dx, w_dy, w_dx_m;
  logic        r_hit1, r_hit2;
  logic [2*IW-1:0] r_addr1;
  logic [1:0]  w_rom_data;

  assign w_vsync_rise = vsync & ~r_vsync_q;

`ifdef BLINK_ON_DEADLOCK_EN
  // A deadlocked bot reports (0,0); keep drawing where it was last seen alive.
  assign w_pos_en = w_vsync_rise & ~deadlock;
`else
  assign w_pos_en = w_vsync_rise;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vsync_q    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_loc_x      <= START_X;
      r_loc_y      <= START_Y;
      r_dir        <= NORTH;
      r_dead       <= 1'b0;
    end else begin
      r_vsync_q    <= vsync;
      r_frame_tick <= w_vsync_rise;
      if (w_vsync_rise) r_dead <= deadlock;
      if (w_pos_en) begin
        r_loc_x <= loc_x;
        r_loc_y <= loc_y;
        r_dir   <= dir_e'(direction);
      end
    end
  end

  assign w_left = 12'(X_OFFSET) + (12'(r_loc_x) << SCALE_SHIFT);
  assign w_top  = 12'(Y_OFFSET) + (12'(r_loc_y) << SCALE_SHIFT);

  assign w_hit = video_on
               & (pixel_column >= w_left) & (pixel_column < w_left + 12'(ICON_W))
               & (pixel_row    >= w_top)  & (pixel_row    < w_top  + 12'(ICON_W));

  assign w_dx = IW'(pixel_column - w_left);
  assign w_dy = IW'(pixel_row - w_top);
  // ICON_W is a power of two, so ICON_W-1-dx is simply the bitwise complement.
  assign w_dx_m = faces_west(r_dir) ? ~w_dx : w_dx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit1  <= 1'b0;
      r_addr1 <= '0;
      r_hit2  <= 1'b0;
    end else begin
      r_hit1  <= w_hit;
      r_addr1 <= {w_dy, w_dx_m};
      r_hit2  <= r_hit1;
    end
  end

  toad_icon_rom u_rom (
    .clk    (clk),
    .i_addr (r_addr1),
    .o_data (w_rom_data)
  );

`ifdef BLINK_ON_DEADLOCK_EN
  localparam int CW = $clog2(BLINK_FRAMES);

  logic [CW-1:0] r_blink_cnt;
  logic          r_blink_vis;

  // Counting starts on the frame after deadlock is latched, giving BLINK_FRAMES frames per phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (!r_dead) begin
      r_blink_cnt <= '0;
      r_blink_vis <= 1'b1;
    end else if (w_vsync_rise) begin
      if (r_blink_cnt == CW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_vis <= ~r_blink_vis;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_show = r_blink_vis;
`else
  assign w_show = ~r_dead;
`endif

  assign icon       = (r_hit2 & w_show) ? w_rom_data : 2'd0;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_toad_icon_render.sv
// Scoreboard bench for toad_icon_render: pixel stimulus queues expected icons, a monitor checks them 2 clocks later.
module tb_toad_icon_render;
  import maze_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b0, video_on = 1'b0, deadlock = 1'b0;
  logic [11:0] pixel_row = '0, pixel_column = '0;
  logic [7:0]  loc_x = '0, loc_y = '0;
  logic [2:0]  direction = '0;
  logic [1:0]  icon;
  logic        frame_tick;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {int cyc; logic [1:0] exp; string name;} item_t;
  item_t q[$];

  // Bench copy of the sprite, row 0 first, pixel dx at bits [2*dx +: 2].
  logic [31:0] img [16] = '{
    32'h0000_0001, 32'h0015_5400, 32'h0155_5540, 32'h05AA_5A53,
    32'h15FF_FF54, 32'h56AA_AA95, 32'h5555_5555, 32'h5A55_55A5,
    32'h5555_5555, 32'h1555_5554, 32'h0555_5550, 32'h0155_5540,
    32'h0510_0450, 32'h1400_0014, 32'h5000_0005, 32'hC000_0003
  };

  int m_x = 68, m_y = 60, m_dir = 0;
  bit m_dead = 1'b0;

  toad_icon_render dut (
    .clk(clk), .rst(rst), .vsync(vsync), .video_on(video_on),
    .pixel_row(pixel_row), .pixel_column(pixel_column),
    .loc_x(loc_x), .loc_y(loc_y), .direction(direction), .deadlock(deadlock),
    .icon(icon), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] model(input int row, input int col, input bit vo);
    int left, top, dx, dy;
    logic [31:0] w;
    left = 256 + m_x * 4;
    top  = 128 + m_y * 4;
    if (!vo || col < left || col >= left + 16 || row < top || row >= top + 16) return 2'd0;
`ifndef BLINK_ON_DEADLOCK_EN
    if (m_dead) return 2'd0;
`endif
    dx = col - left;
    dy = row - top;
    if (m_dir >= 5) dx = 15 - dx;
    w = img[dy];
    return w[2*dx +: 2];
  endfunction

  always @(negedge clk) begin
    item_t it;
    if (q.size() > 0) begin
      if (q[0].cyc + 2 == cyc) begin
        it = q.pop_front();
        check(it.name, icon, it.exp);
      end else if (q[0].cyc + 2 < cyc) begin
        it = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: response window missed at cycle %0d", it.name, cyc);
      end
    end
  end

  task automatic px(input int row, input int col, input bit vo, input logic [1:0] exp, input string name);
    item_t it;
    @(negedge clk);
    pixel_row    = 12'(row);
    pixel_column = 12'(col);
    video_on     = vo;
    it.cyc  = cyc;
    it.exp  = exp;
    it.name = $sformatf("%s r%0d c%0d", name, row, col);
    q.push_back(it);
  endtask

  task automatic frame(input int x, input int y, input int d, input bit dd);
    @(negedge clk);
    video_on  = 1'b0;
    loc_x     = 8'(x);
    loc_y     = 8'(y);
    direction = 3'(d);
    deadlock  = dd;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check("frame_tick_high", frame_tick, 1);
    vsync = 1'b0;
    @(negedge clk);
    check("frame_tick_low", frame_tick, 0);
`ifdef BLINK_ON_DEADLOCK_EN
    if (!dd) begin m_x = x; m_y = y; m_dir = d; end
`else
    m_x = x; m_y = y; m_dir = d;
`endif
    m_dead = dd;
  endtask

  task automatic scan(input string name);
    int left, top;
    left = 256 + m_x * 4;
    top  = 128 + m_y * 4;
    for (int r = -1; r <= 16; r++)
      for (int c = -1; c <= 16; c++)
        px(top + r, left + c, 1'b1, model(top + r, left + c, 1'b1), name);
  endtask

  initial begin
    // Reset held while a vsync pulse and new location arrive: nothing may latch.
    loc_x = 8'd10; loc_y = 8'd20;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_frame_tick", frame_tick, 0);
    check("reset_icon", icon, 0);
    vsync = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    px(368, 527, 1, 2'd0, "rst_left_out");
    px(368, 528, 1, 2'd1, "rst_corner");
    px(383, 543, 1, 2'd3, "rst_far_corner");
    px(384, 543, 1, 2'd0, "rst_below");
    px(367, 528, 1, 2'd0, "rst_above");

    // Latch and exact 2-clock latency.
    frame(10, 20, EAST, 0);
    px(208, 295, 1, 2'd0, "lat_before");
    px(208, 296, 1, 2'd1, "lat_hit");
    px(208, 312, 1, 2'd0, "lat_right_out");
    px(223, 311, 1, 2'd3, "lat_last");

    // Tearing: location change without vsync is ignored until the next frame.
    @(negedge clk);
    loc_x = 8'd11;
    px(208, 296, 1, 2'd1, "tear_old_pos");
    px(208, 300, 1, 2'd0, "tear_not_moved");
    frame(11, 20, EAST, 0);
    px(208, 296, 1, 2'd0, "tear_old_gone");
    px(208, 300, 1, 2'd1, "tear_new_pos");
    scan("scan_east");

    // Mirror: (dy=3, dx=0) reads address 0x3F facing west, 0x30 facing east.
    frame(11, 20, WEST, 0);
    px(211, 300, 1, 2'd0, "mirror_west_dx0");
    px(211, 315, 1, 2'd3, "mirror_west_dx15");
    scan("scan_west");
    frame(11, 20, EAST, 0);
    px(211, 300, 1, 2'd3, "mirror_east_dx0");

    // Far corner of the map: no wrap, video_on gates the hit.
    frame(127, 127, EAST, 0);
    px(636, 764, 1, 2'd1, "edge_corner");
    px(651, 779, 1, 2'd3, "edge_far");
    px(651, 780, 1, 2'd0, "edge_right_out");
    px(652, 779, 1, 2'd0, "edge_below");
    px(635, 764, 1, 2'd0, "edge_above");
    px(636, 764, 0, 2'd0, "video_off");

`ifdef BLINK_ON_DEADLOCK_EN
    frame(5, 5, EAST, 0);
    px(148, 276, 1, 2'd1, "blink_pre");
    for (int f = 1; f <= 31; f++) begin
      frame(0, 0, EAST, 1);
      px(148, 276, 1, (f <= 15 || f == 31) ? 2'd1 : 2'd0, $sformatf("blink_f%0d", f));
    end
    for (int f = 0; f < 3; f++) begin
      frame(5, 5, EAST, 0);
      px(148, 276, 1, 2'd1, "blink_release");
    end
    frame(0, 0, EAST, 0);
`else
    frame(0, 0, EAST, 1);
    for (int r = 128; r < 144; r++)
      for (int c = 256; c < 272; c++)
        px(r, c, 1, 2'd0, "dead_hidden");
    frame(0, 0, EAST, 0);
`endif
    px(128, 256, 1, 2'd1, "alive_origin");

    // Reset mid-frame clears the pipeline at once.
    repeat (3) @(negedge clk);
    pixel_row = 12'd128; pixel_column = 12'd256; video_on = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_icon", icon, 1);
    rst = 1'b0;
    #1;
    check("mid_reset_icon", icon, 0);
    video_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_x = 68; m_y = 60; m_dir = 0; m_dead = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_icon", icon, 0);
    px(368, 528, 1, 2'd1, "post_reset_pos");

    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d items left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
